// File: rtl/pcileech_rst_ctl.sv
// Board reset/input conditioner: 2-FF synchronisers, button debounce, stretched system reset FSM,
// free-running tick counter and heartbeat LED. Optional PERST#-driven PCIe reset: PCILEECH_RSTCTL_PERST_EN.
module pcileech_rst_ctl #(
  parameter int PARAM_DEBOUNCE_CYCLES = 1000000,
  parameter int PARAM_RST_HOLD_CYCLES = 64,
  parameter int PARAM_HEARTBEAT_BIT   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_rst_in,
  input  logic        btn_inv_in,
  input  logic        perst_n_in,
  output logic        rst_sys,
  output logic        ft601_rst_n,
  output logic        rst_pcie,
  output logic        btn_inv,
  output logic        perst_n_sync,
  output logic        led_heartbeat,
  output logic [63:0] tickcount64
);

  localparam int DB_W   = $clog2(PARAM_DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(PARAM_RST_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(PARAM_DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PARAM_RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_BTN  = 2'd2
  } state_t;

  logic [1:0]        btn_rst_sync;
  logic [1:0]        btn_inv_sync;
  logic [1:0]        perst_sync;
  logic [DB_W-1:0]   db_rst_cnt;
  logic [DB_W-1:0]   db_inv_cnt;
  logic              btn_rst_db;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  state_t            state;
  state_t            state_nxt;

  // Stage 0: pad synchronisers; PERST# idles deasserted (high) out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_rst_sync <= 2'b00;
      btn_inv_sync <= 2'b00;
      perst_sync   <= 2'b11;
    end else begin
      btn_rst_sync <= {btn_rst_sync[0], btn_rst_in};
      btn_inv_sync <= {btn_inv_sync[0], btn_inv_in};
      perst_sync   <= {perst_sync[0], perst_n_in};
    end
  end

  assign perst_n_sync = perst_sync[1];

  // Stage 1: debounce; output only flips after the input differs for a full window
  always_ff @(posedge clk) begin
    if (rst) begin
      db_rst_cnt <= '0;
      btn_rst_db <= 1'b0;
    end else if (btn_rst_sync[1] == btn_rst_db) begin
      db_rst_cnt <= '0;
    end else if (db_rst_cnt == DB_LAST) begin
      db_rst_cnt <= '0;
      btn_rst_db <= ~btn_rst_db;
    end else begin
      db_rst_cnt <= db_rst_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_inv_cnt <= '0;
      btn_inv    <= 1'b0;
    end else if (btn_inv_sync[1] == btn_inv) begin
      db_inv_cnt <= '0;
    end else if (db_inv_cnt == DB_LAST) begin
      db_inv_cnt <= '0;
      btn_inv    <= ~btn_inv;
    end else begin
      db_inv_cnt <= db_inv_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tickcount64 <= '0;
    else     tickcount64 <= tickcount64 + 64'd1;
  end

  // Button press wins over hold expiry so a held button is never missed
  always_comb begin
    state_nxt    = S_HOLD;
    hold_cnt_nxt = '0;
    case (state)
      S_HOLD: begin
        if (btn_rst_db) begin
          state_nxt = S_BTN;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt    = S_HOLD;
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      S_RUN:   state_nxt = btn_rst_db ? S_BTN : S_RUN;
      S_BTN:   state_nxt = btn_rst_db ? S_BTN : S_HOLD;
      default: state_nxt = S_HOLD;
    endcase
  end

  // Stage 2: state register and registered reset decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      rst_sys  <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      rst_sys  <= (state != S_RUN);
    end
  end

  assign ft601_rst_n = ~rst_sys;

`ifdef PCILEECH_RSTCTL_PERST_EN
  logic rst_pcie_q;

  // Stage 3: PERST# only gates the PCIe core, never the system reset
  always_ff @(posedge clk) begin
    if (rst) rst_pcie_q <= 1'b1;
    else     rst_pcie_q <= rst_sys | ~perst_sync[1];
  end

  assign rst_pcie = rst_pcie_q;
`else
  assign rst_pcie = rst_sys;
`endif

  assign led_heartbeat = tickcount64[PARAM_HEARTBEAT_BIT] | btn_inv | btn_rst_db;

endmodule

// File: tb/tb_pcileech_rst_ctl.sv
// Self-checking bench for pcileech_rst_ctl with debounce window 8 and reset hold 4.
// Per-cycle expectations are queued as stimulus is applied, then popped and compared after each edge.
module tb_pcileech_rst_ctl;

`ifdef PCILEECH_RSTCTL_PERST_EN
  localparam bit PERST_EN = 1'b1;
`else
  localparam bit PERST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_rst_in;
  logic        btn_inv_in;
  logic        perst_n_in;
  logic        rst_sys;
  logic        ft601_rst_n;
  logic        rst_pcie;
  logic        btn_inv;
  logic        perst_n_sync;
  logic        led_heartbeat;
  logic [63:0] tickcount64;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst_sys;
    logic        led;
    logic        btn_inv;
    logic        rst_pcie;
    logic        perst_n_sync;
    logic [63:0] tick;
  } exp_t;

  exp_t sb[$];

  pcileech_rst_ctl #(
    .PARAM_DEBOUNCE_CYCLES(8),
    .PARAM_RST_HOLD_CYCLES(4),
    .PARAM_HEARTBEAT_BIT  (26)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_rst_in   (btn_rst_in),
    .btn_inv_in   (btn_inv_in),
    .perst_n_in   (perst_n_in),
    .rst_sys      (rst_sys),
    .ft601_rst_n  (ft601_rst_n),
    .rst_pcie     (rst_pcie),
    .btn_inv      (btn_inv),
    .perst_n_sync (perst_n_sync),
    .led_heartbeat(led_heartbeat),
    .tickcount64  (tickcount64)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected timing after a press/release applied before edge 1:
  // sync output flips after edge 2, debounced output after edge 10,
  // FSM state after edge 11, registered rst_sys after edge 12.
  task automatic test_reset();
    exp_t e;
    rst = 1'b1; btn_rst_in = 1'b0; btn_inv_in = 1'b0; perst_n_in = 1'b1;
    repeat (5) step();
    checks++;
    if (rst_sys !== 1'b1 || ft601_rst_n !== 1'b0 || rst_pcie !== 1'b1 || btn_inv !== 1'b0 ||
        perst_n_sync !== 1'b1 || led_heartbeat !== 1'b0 || tickcount64 !== 64'd0) begin
      errors++;
      $display("FAIL reset_values got rst_sys=%b ft601_rst_n=%b rst_pcie=%b btn_inv=%b perst_n_sync=%b led=%b tick=%0d want 1 0 1 0 1 0 0",
               rst_sys, ft601_rst_n, rst_pcie, btn_inv, perst_n_sync, led_heartbeat, tickcount64);
    end
    for (int k = 1; k <= 8; k++) begin
      e = '0;
      e.rst_sys = (k <= 4);
      e.tick    = 64'(k);
      sb.push_back(e);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (rst_sys !== e.rst_sys || ft601_rst_n !== ~e.rst_sys) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got rst_sys=%b ft601_rst_n=%b want rst_sys=%b", k, rst_sys, ft601_rst_n, e.rst_sys);
      end
      checks++;
      if (tickcount64 !== e.tick) begin
        errors++;
        $display("FAIL tick_start cyc=%0d got %0d want %0d", k, tickcount64, e.tick);
      end
    end
  endtask

  task automatic test_btn_rst();
    exp_t e;
    for (int k = 1; k <= 25; k++) begin
      e = '0;
      sb.push_back(e);
    end
    btn_rst_in = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 5) btn_rst_in = 1'b0;
      e = sb.pop_front();
      checks++;
      if (rst_sys !== e.rst_sys || led_heartbeat !== e.led) begin
        errors++;
        $display("FAIL btn_rst_glitch cyc=%0d got rst_sys=%b led=%b want %b %b", k, rst_sys, led_heartbeat, e.rst_sys, e.led);
      end
    end
    for (int k = 1; k <= 40; k++) begin
      e = '0;
      e.led     = (k >= 10 && k <= 29);
      e.rst_sys = (k >= 12 && k <= 35);
      sb.push_back(e);
    end
    btn_rst_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 20) btn_rst_in = 1'b0;
      e = sb.pop_front();
      checks++;
      if (rst_sys !== e.rst_sys || ft601_rst_n !== ~e.rst_sys || led_heartbeat !== e.led) begin
        errors++;
        $display("FAIL btn_rst_press cyc=%0d got rst_sys=%b ft601_rst_n=%b led=%b want rst_sys=%b led=%b",
                 k, rst_sys, ft601_rst_n, led_heartbeat, e.rst_sys, e.led);
      end
    end
  endtask

  task automatic test_btn_inv();
    exp_t e;
    for (int k = 0; k < 50 + 12; k++) begin
      e = '0;
      sb.push_back(e);
    end
    for (int k = 0; k < 50 + 12; k++) begin
      btn_inv_in = (k < 50) ? logic'((k / 3) % 2) : 1'b0;
      step();
      e = sb.pop_front();
      checks++;
      if (btn_inv !== e.btn_inv || led_heartbeat !== e.led) begin
        errors++;
        $display("FAIL btn_inv_toggle cyc=%0d got btn_inv=%b led=%b want %b %b", k, btn_inv, led_heartbeat, e.btn_inv, e.led);
      end
    end
    for (int k = 1; k <= 26; k++) begin
      e = '0;
      e.btn_inv = (k <= 14) ? (k >= 10) : (k - 14 < 10);
      e.led     = e.btn_inv;
      sb.push_back(e);
    end
    btn_inv_in = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 14) btn_inv_in = 1'b0;
      e = sb.pop_front();
      checks++;
      if (btn_inv !== e.btn_inv || led_heartbeat !== e.led || rst_sys !== 1'b0) begin
        errors++;
        $display("FAIL btn_inv_hold cyc=%0d got btn_inv=%b led=%b rst_sys=%b want %b %b 0",
                 k, btn_inv, led_heartbeat, rst_sys, e.btn_inv, e.led);
      end
    end
  endtask

  task automatic test_perst();
    exp_t e;
    for (int k = 1; k <= 14; k++) begin
      e = '0;
      if (k <= 8) begin
        e.perst_n_sync = (k < 2);
        e.rst_pcie     = PERST_EN && (k >= 3);
      end else begin
        e.perst_n_sync = (k - 8 >= 2);
        e.rst_pcie     = PERST_EN && (k - 8 < 3);
      end
      sb.push_back(e);
    end
    perst_n_in = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 8) perst_n_in = 1'b1;
      e = sb.pop_front();
      checks++;
      if (perst_n_sync !== e.perst_n_sync || rst_pcie !== e.rst_pcie || rst_sys !== 1'b0 || ft601_rst_n !== 1'b1) begin
        errors++;
        $display("FAIL perst cyc=%0d got perst_n_sync=%b rst_pcie=%b rst_sys=%b ft601_rst_n=%b want %b %b 0 1",
                 k, perst_n_sync, rst_pcie, rst_sys, ft601_rst_n, e.perst_n_sync, e.rst_pcie);
      end
    end
  endtask

  task automatic test_tick_wrap();
    exp_t e;
    for (int k = 1; k <= 3; k++) begin
      e = '0;
      e.tick = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(k - 2);
      sb.push_back(e);
    end
    force dut.tickcount64 = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.tickcount64;
    for (int k = 1; k <= 3; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (tickcount64 !== e.tick) begin
        errors++;
        $display("FAIL tick_wrap cyc=%0d got %h want %h", k, tickcount64, e.tick);
      end
    end
  endtask

  task automatic test_rst_in_btn();
    exp_t e;
    btn_rst_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      e = '0;
      e.led     = (k >= 10);
      e.rst_sys = (k >= 12);
      sb.push_back(e);
    end
    for (int k = 1; k <= 14; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (rst_sys !== e.rst_sys || led_heartbeat !== e.led) begin
        errors++;
        $display("FAIL rst_btn_enter cyc=%0d got rst_sys=%b led=%b want %b %b", k, rst_sys, led_heartbeat, e.rst_sys, e.led);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rst_sys !== 1'b1 || led_heartbeat !== 1'b0 || tickcount64 !== 64'd0) begin
      errors++;
      $display("FAIL rst_in_btn got rst_sys=%b led=%b tick=%0d want 1 0 0", rst_sys, led_heartbeat, tickcount64);
    end
    for (int k = 1; k <= 16; k++) begin
      e = '0;
      e.led     = (k >= 10);
      e.rst_sys = (k <= 4) || (k >= 12);
      sb.push_back(e);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (rst_sys !== e.rst_sys || ft601_rst_n !== ~e.rst_sys || led_heartbeat !== e.led) begin
        errors++;
        $display("FAIL rst_btn_redebounce cyc=%0d got rst_sys=%b led=%b want %b %b", k, rst_sys, led_heartbeat, e.rst_sys, e.led);
      end
    end
    btn_rst_in = 1'b0;
    repeat (30) step();
    checks++;
    if (rst_sys !== 1'b0 || led_heartbeat !== 1'b0) begin
      errors++;
      $display("FAIL rst_btn_release got rst_sys=%b led=%b want 0 0", rst_sys, led_heartbeat);
    end
  endtask

  initial begin
    test_reset();
    test_btn_rst();
    test_btn_inv();
    test_perst();
    test_tick_wrap();
    test_rst_in_btn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
